// File: rtl/naive_bus_ram_pkg.sv
// Shared types and constants for the naive_bus RAM slice.
// Byte-lane geometry and the controller state encoding live here.
package naive_bus_ram_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  typedef enum logic [1:0] {
    INIT,
    CLEAR,
    READY
  } state_e;

endpackage

// File: rtl/naive_bus.sv
// Simple request/grant bus with independent read and write channels.
// A transfer happens on any rising edge where req and gnt are both high.
interface naive_bus;

  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_gnt, rd_data, wr_gnt
  );

endinterface

// File: rtl/nb_ram_lane.sv
// One byte lane of storage: simple dual-port RAM, synchronous write and read.
// A read and write to the same entry in one cycle returns the old contents.
module nb_ram_lane
  import naive_bus_ram_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [LANE_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [LANE_W-1:0] rdata
);

  logic [LANE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/naive_bus_ram.sv
// Word-addressed RAM slave on naive_bus with byte enables and range checking.
// Define NAIVE_BUS_RAM_ZEROIZE_EN to zero the whole array after every reset.
module naive_bus_ram
  import naive_bus_ram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          OUT_REG   = 0
) (
  input  logic     clk,
  input  logic     rst,
  naive_bus.slave  bus,
  output logic     o_ready,
  output logic     o_err
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH) << 2;

  state_e state, state_nxt;

  logic [31:0]             rd_off, wr_off;
  logic                    rd_in, wr_in;
  logic [AW-1:0]           rd_idx, wr_idx;
  logic [LANES-1:0]        lane_we;
  logic [AW-1:0]           lane_waddr;
  logic [LANES*LANE_W-1:0] lane_wdata;
  logic [LANES*LANE_W-1:0] lane_q;
  logic                    rd_zero;
  logic [31:0]             fwd_data;
  logic [LANES-1:0]        fwd_be;
  logic [31:0]             rd_raw;

  assign rd_off = bus.rd_addr - BASE_ADDR;
  assign wr_off = bus.wr_addr - BASE_ADDR;
  assign rd_in  = (bus.rd_addr >= BASE_ADDR) && (rd_off < SPAN);
  assign wr_in  = (bus.wr_addr >= BASE_ADDR) && (wr_off < SPAN);
  assign rd_idx = rd_off[AW+1:2];
  assign wr_idx = wr_off[AW+1:2];

  assign o_ready    = (state == READY);
  assign bus.rd_gnt = bus.rd_req & o_ready;
  assign bus.wr_gnt = bus.wr_req & o_ready;

`ifdef NAIVE_BUS_RAM_ZEROIZE_EN
  logic [AW-1:0] clr_cnt;
  logic          clr_last;

  assign clr_last = (clr_cnt == AW'(DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_last ? '0 : clr_cnt + AW'(1);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT: begin
`ifdef NAIVE_BUS_RAM_ZEROIZE_EN
        state_nxt = CLEAR;
`else
        state_nxt = READY;
`endif
      end
`ifdef NAIVE_BUS_RAM_ZEROIZE_EN
      CLEAR:   if (clr_last) state_nxt = READY;
`endif
      READY:   state_nxt = READY;
      default: state_nxt = INIT;
    endcase
  end

  // Grants only happen in READY, so the zeroize sweep never competes with the bus.
  always_comb begin
    lane_we    = '0;
    lane_waddr = wr_idx;
    lane_wdata = bus.wr_data;
    if (bus.wr_gnt && wr_in) lane_we = bus.wr_be;
`ifdef NAIVE_BUS_RAM_ZEROIZE_EN
    if (state == CLEAR) begin
      lane_we    = '1;
      lane_waddr = clr_cnt;
      lane_wdata = '0;
    end
`endif
  end

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    nb_ram_lane #(.DEPTH(DEPTH)) u_lane (
      .clk   (clk),
      .we    (lane_we[n]),
      .waddr (lane_waddr),
      .wdata (lane_wdata[n*LANE_W +: LANE_W]),
      .re    (bus.rd_gnt),
      .raddr (rd_idx),
      .rdata (lane_q[n*LANE_W +: LANE_W])
    );
  end

  // Lanes return pre-write data, so same-word write bytes are captured here and merged on output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_zero  <= 1'b1;
      fwd_data <= '0;
      fwd_be   <= '0;
    end else if (bus.rd_gnt) begin
      rd_zero  <= !rd_in;
      fwd_data <= bus.wr_data;
      fwd_be   <= (bus.wr_gnt && wr_in && rd_in && (wr_idx == rd_idx)) ? bus.wr_be : '0;
    end
  end

  always_comb begin
    rd_raw = '0;
    if (!rd_zero) begin
      for (int n = 0; n < LANES; n++) begin
        rd_raw[n*LANE_W +: LANE_W] = fwd_be[n] ? fwd_data[n*LANE_W +: LANE_W]
                                               : lane_q[n*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_err <= 1'b0;
    else if ((bus.rd_gnt && !rd_in) || (bus.wr_gnt && !wr_in)) o_err <= 1'b1;
  end

  if (OUT_REG != 0) begin : g_oreg
    logic        rd_vld;
    logic [31:0] rd_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_vld <= 1'b0;
        rd_q   <= '0;
      end else begin
        rd_vld <= bus.rd_gnt;
        if (rd_vld) rd_q <= rd_raw;
      end
    end

    assign bus.rd_data = rd_q;
  end else begin : g_noreg
    assign bus.rd_data = rd_raw;
  end

endmodule

// File: doc/naive_bus_ram.md
NAIVE_BUS_RAM -- requirements
Module: naive_bus_ram

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0000, byte address of word 0; SHALL be DEPTH*4-aligned.
REQ-002 Parameter DEPTH, 1024, number of 32-bit words; SHALL be a power of two, 16..65536.
REQ-003 Parameter OUT_REG, 0, 1 adds an output register stage to rd_data.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 bus  naive_bus.slave  -  rd_req/rd_gnt/rd_addr/rd_data, wr_req/wr_gnt/wr_addr/wr_data/wr_be[3:0].
REQ-007 o_ready  output  1  high when the block accepts requests.
REQ-008 o_err  output  1  sticky out-of-range access flag.

Function
REQ-009 Word index SHALL be (addr - BASE_ADDR)[log2(DEPTH)+1:2]; addr[1:0] SHALL be ignored.
REQ-010 In range SHALL mean BASE_ADDR <= addr < BASE_ADDR + DEPTH*4, compared at full 32-bit width.
REQ-011 rd_gnt SHALL equal rd_req & o_ready and wr_gnt SHALL equal wr_req & o_ready, combinationally.
REQ-012 A granted write SHALL update byte lane n only where wr_be[n]=1, at the grant edge.
REQ-013 A granted read SHALL present data on rd_data 1 cycle after grant (OUT_REG=0) or 2 cycles after (OUT_REG=1).
REQ-014 rd_data SHALL hold its last value while no new read completes.
REQ-015 A same-cycle granted read and write to the same word SHALL return the merged data: wr_data bytes where wr_be=1, old bytes elsewhere.
REQ-016 An out-of-range granted read SHALL return 32'h0; an out-of-range granted write SHALL modify no storage.
REQ-017 Any out-of-range granted access SHALL set o_err on the next edge; o_err SHALL clear only on rst.
REQ-018 FSM states: INIT, CLEAR, READY. INIT->CLEAR or INIT->READY per REQ-024/025 on the first edge after rst deasserts; CLEAR->READY after the last word is written.
REQ-019 o_ready SHALL be 1 only in READY.
REQ-020 Assertion of rst mid-access or mid-CLEAR SHALL abort the operation; after release, the block SHALL restart from INIT.

Reset
REQ-021 During rst: state=INIT, o_ready=0, o_err=0, rd_data=0, pipeline valid bits=0.
REQ-022 Storage contents SHALL NOT be reset, except through CLEAR.

Configuration
REQ-023 The zeroize feature SHALL be controlled by the macro NAIVE_BUS_RAM_ZEROIZE_EN.
REQ-024 Macro defined: CLEAR SHALL write 32'h0 to word 0..DEPTH-1, one per cycle, via a wrap-checked counter; READY SHALL be reached DEPTH+1 cycles after rst release.
REQ-025 Macro undefined: the CLEAR state and counter SHALL be absent; INIT->READY SHALL take 1 cycle.

Structure
REQ-026 Package naive_bus_ram_pkg SHALL hold the state enum (INIT/CLEAR/READY), LANES=4, and LANE_W=8.
REQ-027 Sub-module nb_ram_lane: one 8-bit simple dual-port RAM, synchronous read and write, DEPTH entries, instantiated LANES times.
REQ-028 Forwarding, range check, FSM and output register SHALL reside in naive_bus_ram.

Verification
REQ-029 Configuration: DEPTH=16, BASE_ADDR=32'h1000, zeroize on. Release rst -> o_ready rises 17 cycles later; read 0x1000..0x103C -> all 32'h0.
REQ-030 Write 0x1004 data 32'hAABBCCDD with wr_be=4'b0101, over 32'h11223344 -> read returns 32'h11BB33DD at latency 1 (OUT_REG=0) and at latency 2 (OUT_REG=1).
REQ-031 Same-cycle write 0x1008 data 32'hDEADBEEF with be=4'b1100 and read 0x1008 (old 32'h0) -> rd_data=32'hDEAD0000 next cycle.
REQ-032 Read 0x2000 -> rd_data=32'h0 and o_err=1 next cycle; write 0x0FFC -> no word changed; o_err stays 1 until rst.
REQ-033 Assert rst at CLEAR count 5 -> o_ready=0 and rd_gnt=0 throughout; after release, CLEAR restarts at word 0 and o_ready rises after 17 cycles.
REQ-034 Macro undefined: o_ready=1 one cycle after rst release; storage keeps preset contents.
